// File: rtl/seq_div_if.sv
// Handshake/result bundle between the HI/LO controller (master) and seq_div (slave).
interface seq_div_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    start;
    logic [DATA_WIDTH-1:0]   a;
    logic [DATA_WIDTH-1:0]   b;
    logic                    signed_op;
    logic                    busy;
    logic                    done;
    logic                    dbz;
    logic [2*DATA_WIDTH-1:0] y;

    modport master (output start, a, b, signed_op, input busy, done, dbz, y);
    modport slave  (input start, a, b, signed_op, output busy, done, dbz, y);
endinterface

// File: rtl/seq_div.sv
// Multi-cycle restoring divider, one quotient bit per cycle; y = {remainder, quotient} for HI/LO.
// Optional signed support is compiled in when DIV_SIGNED_EN is defined.
module seq_div #(
    parameter int DATA_WIDTH = 32
) (
    input logic   clk,
    input logic   rst,
    seq_div_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;

    logic [W-1:0]   rem, quo, dvs;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] y_q;
    logic           dbz_q;
    logic           accept, last;
    logic [W:0]     shifted;
    logic [W-1:0]   diff, rem_n, quo_n, rem_fix, quo_fix;
    logic [W-1:0]   a_mag, b_mag;
    logic           ge;

    assign accept = bus.start && (state != RUN);
    assign last   = (state == RUN) && (cnt == CW'(1));

    // Restoring step: shift in the next dividend bit, keep the difference only if it fits.
    assign shifted = {rem, quo[W-1]};
    assign ge      = shifted >= {1'b0, dvs};
    assign diff    = shifted[W-1:0] - dvs;
    assign rem_n   = ge ? diff : shifted[W-1:0];
    assign quo_n   = {quo[W-2:0], ge};

`ifdef DIV_SIGNED_EN
    logic a_neg, b_neg, neg_q, neg_r;
    assign a_neg   = bus.signed_op & bus.a[W-1];
    assign b_neg   = bus.signed_op & bus.b[W-1];
    assign a_mag   = a_neg ? -bus.a : bus.a;
    assign b_mag   = b_neg ? -bus.b : bus.b;
    // Min/-1 falls out naturally: magnitude quotient 2^(W-1), no negation.
    assign quo_fix = neg_q ? -quo_n : quo_n;
    assign rem_fix = neg_r ? -rem_n : rem_n;
`else
    logic signed_unused;
    assign signed_unused = bus.signed_op;
    assign a_mag   = bus.a;
    assign b_mag   = bus.b;
    assign quo_fix = quo_n;
    assign rem_fix = rem_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: begin
                if (bus.start)          state_n = (bus.b == '0) ? DONE : RUN;
                else if (state == DONE) state_n = IDLE;
            end
            RUN:     if (cnt == CW'(1)) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            y_q   <= '0;
            dbz_q <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q <= 1'b0;
            neg_r <= 1'b0;
`endif
        end else if (accept) begin
            if (bus.b == '0) begin
                y_q   <= {bus.a, {W{1'b1}}};
                dbz_q <= 1'b1;
            end else begin
                rem <= '0;
                quo <= a_mag;
                dvs <= b_mag;
                cnt <= CW'(W);
`ifdef DIV_SIGNED_EN
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
`endif
            end
        end else if (state == RUN) begin
            rem <= rem_n;
            quo <= quo_n;
            cnt <= cnt - CW'(1);
            if (last) begin
                y_q   <= {rem_fix, quo_fix};
                dbz_q <= 1'b0;
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.y    = y_q;
    assign bus.dbz  = dbz_q;
endmodule

// File: tb/tb_seq_div.sv
// Randomized scoreboard bench for seq_div: stimulus pushes expected results, a monitor checks on done.
module tb_seq_div;
    localparam int W = 32;
`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef struct {
        logic [2*W-1:0] y;
        logic           dbz;
        int             due;
    } exp_t;

    logic clk, rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    seq_div_if #(.DATA_WIDTH(W)) bus();
    seq_div #(.DATA_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division; signed uses truncating division with min/-1 special-cased.
    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic s);
        exp_t e;
        logic signed [W-1:0] sa, sb_;
        logic [W-1:0] minv;
        minv  = {1'b1, {(W-1){1'b0}}};
        sa    = ia;
        sb_   = ib;
        e.dbz = 1'b0;
        e.due = 0;
        if (ib == '0) begin
            e.y   = {ia, {W{1'b1}}};
            e.dbz = 1'b1;
        end else if (s && SIGNED_EN) begin
            if (ia == minv && ib == '1) e.y = {{W{1'b0}}, minv};
            else                        e.y = {W'(sa % sb_), W'(sa / sb_)};
        end else begin
            e.y = {ia % ib, ia / ib};
        end
        return e;
    endfunction

    // Called at a negedge; returns at the following negedge with start dropped.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic s);
        exp_t e;
        bus.start     = 1'b1;
        bus.a         = ia;
        bus.b         = ib;
        bus.signed_op = s;
        if (!bus.busy) begin
            e     = model(ia, ib, s);
            e.due = cyc + 1 + ((ib == '0) ? 0 : W);
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start     = 1'b0;
        bus.a         = $urandom;
        bus.b         = $urandom;
        bus.signed_op = 1'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            if (bus.done) break;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80; i++) begin
            if (!bus.busy && !bus.done && sb.size() == 0) break;
            @(negedge clk);
        end
    endtask

    // Monitor: compare every done against the oldest expectation, including its arrival cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: got done=1 expected no result pending (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("y", bus.y, e.y);
                    chk("dbz", 64'(bus.dbz), 64'(e.dbz));
                    chk("latency", 64'(cyc), 64'(e.due));
                    chk("busy_with_done", 64'(bus.busy), 64'd0);
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                checks++;
                errors++;
                $display("FAIL timeout: got no done by cycle %0d expected at %0d", cyc, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.signed_op = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_dbz", 64'(bus.dbz), 64'd0);
        chk("rst_y", bus.y, 64'd0);
        rst = 1'b0;

        issue(32'd100, 32'd7, 1'b0);          wait_idle();
        issue(32'hFFFF_FFFF, 32'd1, 1'b0);    wait_idle();
        issue(32'd5, 32'd9, 1'b0);            wait_idle();
        issue(32'h1234, 32'd0, 1'b0);         wait_idle();

        // Start while busy must be ignored.
        issue(32'd100, 32'd7, 1'b0);
        repeat (5) @(negedge clk);
        issue(32'd1000, 32'd3, 1'b0);
        wait_idle();

        // Back-to-back: new start in the DONE cycle.
        issue(32'd200, 32'd9, 1'b0);
        wait_done();
        issue(32'd100, 32'd7, 1'b0);
        wait_idle();

        // Reset mid-RUN.
        issue(32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        chk("midrst_y", bus.y, 64'd0);
        chk("midrst_dbz", 64'(bus.dbz), 64'd0);
        rst = 1'b0;
        issue(32'd100, 32'd7, 1'b0);          wait_idle();

        // Signed cases; in the unsigned build signed_op must be ignored.
        issue(-32'sd7, 32'd2, 1'b1);          wait_idle();
        issue(32'd7, -32'sd2, 1'b1);          wait_idle();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_idle();
        issue(32'hFFFF_FF00, 32'd0, 1'b1);    wait_idle();

        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1, 2:    rb = W'($urandom_range(1, 15));
                3:       rb = '1;
                default: rb = $urandom;
            endcase
            issue(ra, rb, 1'($urandom));
            if ($urandom_range(0, 1) == 1) wait_done();
            else                           wait_idle();
        end
        wait_idle();
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending: got %0d outstanding expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_div.md
# seq_div

Multi-cycle restoring divider for the MIPS datapath; the inverse of the inferred multiplier. It takes a dividend and divisor on a start pulse and iterates one quotient bit per cycle. It then presents a double-width result {remainder, quotient} that loads the same HI/LO register pair the multiplier's 64-bit product feeds. The controller holds the HI/LO write enable off until `done`.

## Interface
- `DATA_WIDTH`, 32, operand width W; result is 2W bits.
- `clk`  in  1  rising-edge clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `a`  in  W  dividend; sampled on the accepting edge only.
- `b`  in  W  divisor; sampled on the accepting edge only.
- `signed_op`  in  1  signed request; ignored unless DIV_SIGNED_EN is defined.
- `busy`  out  1  iteration in progress.
- `done`  out  1  one-cycle pulse; `y` and `dbz` are valid from this cycle on.
- `dbz`  out  1  divide-by-zero flag for the last result.
- `y`  out  2W  {remainder[W-1:0], quotient[W-1:0]}; upper half maps to HI, lower half to LO.

## Operation
- States:
  - IDLE: `busy`=0, `done`=0.
  - RUN: `busy`=1, `done`=0.
  - DONE: `busy`=0, `done`=1.
- Transitions:
  - IDLE or DONE with `start`=1 and `b`≠0 → RUN. On this edge, latch the operands, clear the partial remainder, load count = W.
  - IDLE or DONE with `start`=1 and `b`=0 → DONE directly.
  - RUN: each edge performs one restoring step and decrements count. The edge that completes step W → DONE.
  - DONE without `start` → IDLE.
- Restoring step:
  - Shift {R, Q} left one bit, bringing in the dividend MSB.
  - Trial subtract: R' = R − divisor, computed at W+1 bits.
  - If non-negative, R ← R' and Q[0] ← 1; else R is unchanged and Q[0] ← 0.
- Unsigned result: quotient = floor(a/b), remainder = a − quotient·b.
- Divide by zero: `y` = {a, all-ones}, `dbz`=1, `done` pulses on the cycle after acceptance.
- `y` and `dbz` update only on entry to DONE and are held until the next result. `y` is never partially updated while RUN.
- `start` while `busy`=1 is ignored: no restart and no queueing.
- `start` in the DONE cycle is accepted: the new operation begins and the old `y` stays held until the new DONE.
- Reset at any point, including mid-RUN: next state IDLE; `busy`=0, `done`=0, `dbz`=0, `y`=0, count=0.

## Timing
- Accepting edge E0 (`start`=1, `busy`=0).
- Divisor nonzero:
  - `busy`=1 in cycles after E0 through edge EW.
  - `done`=1 for exactly the cycle after EW, so latency is W+1 edges (33 for W=32).
  - `busy` and `done` are never both 1.
- Divisor zero: `done`=1 in the cycle after E0 (latency 1).
- Throughput: one division per W+1 cycles when back-to-back `start` is issued in the DONE cycle.

## Configuration
- `DIV_SIGNED_EN` defined, `signed_op`=1:
  - Operands are converted to magnitudes at E0.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - The fix-up is applied on the DONE entry edge, so latency is unchanged.
  - Overflow case −2^(W−1) / −1 yields quotient 0x80000000 and remainder 0 (W=32), with `dbz`=0.
  - Divide by zero behaves as in unsigned mode: `y` = {a, all-ones}.
- `DIV_SIGNED_EN` defined, `signed_op`=0: unsigned operation.
- `DIV_SIGNED_EN` undefined: `signed_op` is unused; all operations are unsigned; no sign logic is synthesized.

## Test plan
- Basic unsigned: reset, then `a`=100, `b`=7, `start` one cycle → `busy` for 32 cycles, `done` pulses at edge 33, `y`=0x00000002_0000000E, `dbz`=0.
- Extremes: `a`=0xFFFFFFFF, `b`=1 → `y`=0x00000000_FFFFFFFF. Then `a`=5, `b`=9 → `y`=0x00000005_00000000.
- Divide by zero: `a`=0x1234, `b`=0 → `done` in the cycle after E0, `dbz`=1, `y`=0x00001234_FFFFFFFF.
- Busy and back-to-back:
  - Pulse `start` with new operands mid-RUN → ignored, and the original result is produced.
  - Pulse `start` in the DONE cycle with 100/7 → second `done` arrives 33 edges later.
- Reset mid-RUN: assert `rst` at iteration 10 → next cycle `busy`=0, `done`=0, `y`=0. A following 100/7 completes correctly.
- Signed (`DIV_SIGNED_EN`, `signed_op`=1):
  - −7/2 → `y`=0xFFFFFFFF_FFFFFFFD.
  - 7/−2 → `y`=0x00000001_FFFFFFFD.
  - 0x80000000/0xFFFFFFFF → `y`=0x00000000_80000000.
